// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel synchronizer and glitch filter.
package sync_pkg;

  localparam int MIN_STAGES = 2;

  // Per-cycle decision taken by a channel's persistence filter.
  typedef enum logic [1:0] {
    FILT_IDLE,
    FILT_COUNT,
    FILT_TAKE
  } filt_act_e;

  function automatic int cnt_width(input int filt);
    return (filt < 1) ? 1 : $clog2(filt + 1);
  endfunction

endpackage

// File: rtl/sync_multi_filt_ch.sv
// One channel: synchronizer chain, persistence filter and edge-pulse decode.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILT    = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic c,
  input  logic r,
  input  logic d,
  output logic osync,
  output logic ofilt,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              ofilt_prev_q, ofilt_prev_d;

  always_comb begin
    sync_d       = {sync_q[STAGES-2:0], d};
    ofilt_prev_d = ofilt;
  end

  always_ff @(posedge c) begin
    if (r) begin
      sync_q       <= {STAGES{RST_VAL}};
      ofilt_prev_q <= RST_VAL;
    end else begin
      sync_q       <= sync_d;
      ofilt_prev_q <= ofilt_prev_d;
    end
  end

  assign osync = sync_q[STAGES-1];

  generate
    if (FILT == 0) begin : g_bypass
      assign ofilt = osync;
    end else begin : g_filt
      localparam int CW = cnt_width(FILT);
      typedef logic [CW-1:0] cnt_t;

      cnt_t      cnt_q, cnt_d;
      logic      filt_q, filt_d;
      filt_act_e act;

      // A new level is adopted only after it has differed from ofilt for FILT cycles.
      always_comb begin
        act    = FILT_IDLE;
        cnt_d  = '0;
        filt_d = filt_q;
        if (osync != filt_q) begin
          act = (cnt_q == cnt_t'(FILT - 1)) ? FILT_TAKE : FILT_COUNT;
        end
        case (act)
          FILT_COUNT: cnt_d  = cnt_q + cnt_t'(1);
          FILT_TAKE:  filt_d = osync;
          default:    cnt_d  = '0;
        endcase
      end

      always_ff @(posedge c) begin
        if (r) begin
          cnt_q  <= '0;
          filt_q <= RST_VAL;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign ofilt = filt_q;
    end
  endgenerate

  assign rise = ofilt & ~ofilt_prev_q;
  assign fall = ~ofilt & ofilt_prev_q;

endmodule

// File: rtl/sync_multi_filt.sv
// CH independent async inputs, each synchronized, glitch-filtered and edge-decoded.
module sync_multi_filt
  import sync_pkg::*;
#(
  parameter int   CH      = 4,
  parameter int   STAGES  = 2,
  parameter int   FILT    = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic          c,
  input  logic          r,
  input  logic [CH-1:0] d,
  output logic [CH-1:0] osync,
  output logic [CH-1:0] ofilt,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  generate
    if (STAGES < MIN_STAGES) begin : g_bad_stages
      $error("sync_multi_filt: STAGES must be at least 2");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
      sync_filt_ch #(
        .STAGES (STAGES),
        .FILT   (FILT),
        .RST_VAL(RST_VAL)
      ) u_ch (
        .c    (c),
        .r    (r),
        .d    (d[i]),
        .osync(osync[i]),
        .ofilt(ofilt[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sync_multi_filt.sv
// Directed bench: default instance (2 stages, filter 3) plus a 3-stage bypass instance resetting high.
module tb_sync_multi_filt;

  logic       clk;
  logic       r, r2;
  logic [3:0] d, d2;
  logic [3:0] osync, ofilt, rise, fall;
  logic [3:0] osync2, ofilt2, rise2, fall2;

  int errors = 0;
  int checks = 0;

  sync_multi_filt #(.CH(4), .STAGES(2), .FILT(3), .RST_VAL(1'b0)) u_dut (
    .c(clk), .r(r), .d(d), .osync(osync), .ofilt(ofilt), .rise(rise), .fall(fall)
  );

  sync_multi_filt #(.CH(4), .STAGES(3), .FILT(0), .RST_VAL(1'b1)) u_alt (
    .c(clk), .r(r2), .d(d2), .osync(osync2), .ofilt(ofilt2), .rise(rise2), .fall(fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    r = 1'b1;
    d = 4'hF;
    for (int k = 1; k <= 2; k++) begin
      cyc();
      checks++;
      if ({osync, ofilt, rise, fall} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold k=%0d osync=%h ofilt=%h rise=%h fall=%h required all 0", k, osync, ofilt, rise, fall);
      end
    end
    @(negedge clk);
    r = 1'b0;
    cyc();
    checks++;
    if ({osync, ofilt, rise, fall} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_release osync=%h ofilt=%h rise=%h fall=%h required all 0", osync, ofilt, rise, fall);
    end
    // Clear d before the high level can survive the filter, then idle.
    @(negedge clk);
    d = 4'h0;
    for (int k = 0; k < 8; k++) cyc();
    checks++;
    if ({ofilt, rise, fall} !== 12'h0) begin
      errors++;
      $display("[TB] FAIL reset_idle ofilt=%h rise=%h fall=%h required 0", ofilt, rise, fall);
    end
  endtask

  task automatic test_rise();
    logic [3:0] exp_sync, exp_filt, exp_rise;
    @(negedge clk);
    d = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp_sync = (k >= 2) ? 4'b0001 : 4'b0000;
      exp_filt = (k >= 5) ? 4'b0001 : 4'b0000;
      exp_rise = (k == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (osync !== exp_sync || ofilt !== exp_filt || rise !== exp_rise || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL rise_ch0 k=%0d got osync=%h ofilt=%h rise=%h fall=%h required %h %h %h 0",
                 k, osync, ofilt, rise, fall, exp_sync, exp_filt, exp_rise);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_s1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d = (k <= 2) ? 4'b0011 : 4'b0001;
      cyc();
      exp_s1 = (k == 2 || k == 3);
      checks++;
      if (osync[1] !== exp_s1 || ofilt !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL glitch_ch1 k=%0d got osync1=%b ofilt=%h rise=%h fall=%h required %b 1 0 0",
                 k, osync[1], ofilt, rise, fall, exp_s1);
      end
    end
  endtask

  task automatic test_toggle();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      d = {2'b00, k[0], 1'b1};
      cyc();
      checks++;
      if (ofilt !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL toggle_ch1 k=%0d ofilt=%h rise=%h fall=%h required 1 0 0", k, ofilt, rise, fall);
      end
    end
    @(negedge clk);
    d = 4'b0001;
    for (int k = 0; k < 6; k++) cyc();
  endtask

  task automatic test_simul_fall();
    logic [3:0] exp_filt, exp_fall;
    @(negedge clk);
    d = 4'b1101;
    for (int k = 0; k < 8; k++) cyc();
    checks++;
    if (ofilt !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL settle_high ofilt=%h required d", ofilt);
    end
    @(negedge clk);
    d = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp_filt = (k >= 5) ? 4'b0001 : 4'b1101;
      exp_fall = (k == 5) ? 4'b1100 : 4'b0000;
      checks++;
      if (ofilt !== exp_filt || fall !== exp_fall || rise !== 4'h0) begin
        errors++;
        $display("[TB] FAIL simul_fall k=%0d ofilt=%h fall=%h rise=%h required %h %h 0",
                 k, ofilt, fall, rise, exp_filt, exp_fall);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    r = 1'b1;
    d = 4'h0;
    cyc();
    cyc();
    @(negedge clk);
    r = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    checks++;
    if ({osync, ofilt, rise, fall} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre osync=%h ofilt=%h rise=%h fall=%h required all 0", osync, ofilt, rise, fall);
    end
    @(negedge clk);
    d = 4'b0001;
    for (int k = 0; k < 3; k++) cyc();
    @(negedge clk);
    r = 1'b1;
    cyc();
    checks++;
    if (osync !== 4'h0 || ofilt !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_edge osync=%h ofilt=%h rise=%h fall=%h required all 0", osync, ofilt, rise, fall);
    end
    @(negedge clk);
    r = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (rise[0] !== (k == 5) || ofilt[0] !== (k >= 5) || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset_mid_after k=%0d rise0=%b ofilt0=%b fall=%h required %b %b 0",
                 k, rise[0], ofilt[0], fall, (k == 5), (k >= 5));
      end
    end
  endtask

  task automatic test_bypass_high();
    logic [3:0] exp_filt, exp_fall;
    @(negedge clk);
    r2 = 1'b1;
    d2 = 4'hF;
    cyc();
    cyc();
    checks++;
    if (osync2 !== 4'hF || ofilt2 !== 4'hF || rise2 !== 4'h0 || fall2 !== 4'h0) begin
      errors++;
      $display("[TB] FAIL alt_reset osync=%h ofilt=%h rise=%h fall=%h required f f 0 0", osync2, ofilt2, rise2, fall2);
    end
    @(negedge clk);
    r2 = 1'b0;
    cyc();
    checks++;
    if (ofilt2 !== 4'hF || rise2 !== 4'h0 || fall2 !== 4'h0) begin
      errors++;
      $display("[TB] FAIL alt_release ofilt=%h rise=%h fall=%h required f 0 0", ofilt2, rise2, fall2);
    end
    @(negedge clk);
    d2 = 4'hE;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      exp_filt = (k >= 3) ? 4'hE : 4'hF;
      exp_fall = (k == 3) ? 4'b0001 : 4'b0000;
      checks++;
      if (ofilt2 !== exp_filt || osync2 !== exp_filt || fall2 !== exp_fall || rise2 !== 4'h0) begin
        errors++;
        $display("[TB] FAIL alt_fall k=%0d osync=%h ofilt=%h fall=%h rise=%h required %h %h %h 0",
                 k, osync2, ofilt2, fall2, rise2, exp_filt, exp_filt, exp_fall);
      end
    end
  endtask

  initial begin
    r  = 1'b1;
    d  = 4'h0;
    r2 = 1'b1;
    d2 = 4'hF;
    test_reset();
    test_rise();
    test_glitch();
    test_toggle();
    test_simul_fall();
    test_reset_mid();
    test_bypass_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
